// File: rtl/bp_cfg_loader_pkg.sv
// bp_cfg_loader_pkg: shared state encoding, packet layout and width helpers for the config loader
package bp_cfg_loader_pkg;

    typedef enum logic [1:0] {
        e_idle     = 2'd0,
        e_send     = 2'd1,
        e_unfreeze = 2'd2,
        e_done     = 2'd3
    } bp_cfg_loader_state_e;

    function automatic int bp_safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] bp_freeze_idx(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

`define BP_CFG_PKT_S(cw, fw, dw) struct packed { logic [(cw)-1:0] core; logic [(fw)-1:0] field; logic [(dw)-1:0] data; }

// File: rtl/bp_cfg_next_core.sv
// bp_cfg_next_core: lowest set mask bit strictly above i_cur (i_cur all-ones means -1)
module bp_cfg_next_core
    import bp_cfg_loader_pkg::*;
#(
    parameter int num_core_p      = 4,
    parameter int core_id_width_p = bp_safe_clog2(num_core_p)
) (
    input  logic [num_core_p-1:0]      i_mask,
    input  logic [core_id_width_p:0]   i_cur,
    output logic [core_id_width_p-1:0] o_core,
    output logic                       o_found
);

    logic [core_id_width_p:0] w_lo;

    assign w_lo = i_cur + (core_id_width_p + 1)'(1);

    always_comb begin
        o_core  = '0;
        o_found = 1'b0;
        for (int i = num_core_p - 1; i >= 0; i--)
            if (i_mask[i] && ((core_id_width_p + 1)'(i) >= w_lo)) begin
                o_core  = core_id_width_p'(i);
                o_found = 1'b1;
            end
    end

endmodule

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: host-overridable config table broadcast to each enabled core, then freeze-release
module bp_cfg_loader
    import bp_cfg_loader_pkg::*;
#(
    parameter int num_core_p       = 4,
    parameter int num_fields_p     = 8,
    parameter int field_width_p    = 64,
    parameter logic [num_fields_p*field_width_p-1:0] default_fields_p = '0,
    parameter int freeze_release_p = 1,
    parameter int core_id_width_p  = bp_safe_clog2(num_core_p),
    parameter int field_id_width_p = bp_safe_clog2(num_fields_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [num_core_p-1:0]       core_mask_i,
    input  logic                        ovr_v_i,
    output logic                        ovr_ready_o,
    input  logic [field_id_width_p-1:0] ovr_addr_i,
    input  logic [field_width_p-1:0]    ovr_data_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_id_width_p-1:0]  cfg_core_o,
    output logic [field_id_width_p-1:0] cfg_field_o,
    output logic [field_width_p-1:0]    cfg_data_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int fiw = bp_safe_clog2(num_fields_p);
    localparam logic [31:0] freeze_full = bp_freeze_idx(field_id_width_p);
    localparam logic [field_id_width_p-1:0] freeze_idx = freeze_full[field_id_width_p-1:0];
    localparam logic [field_id_width_p-1:0] last_field = field_id_width_p'(num_fields_p - 1);

    typedef `BP_CFG_PKT_S(core_id_width_p, field_id_width_p, field_width_p) pkt_t;

    bp_cfg_loader_state_e      r_state;
    logic [field_width_p-1:0]  r_table [num_fields_p];
    logic [num_core_p-1:0]     r_mask;
    logic [core_id_width_p-1:0] r_core;
    logic [field_id_width_p-1:0] r_field;

    logic w_idle, w_start, w_ovr_we, w_hs, w_last, w_adv, w_found;
    logic [num_core_p-1:0]      w_mask;
    logic [core_id_width_p:0]   w_cur;
    logic [core_id_width_p-1:0] w_next;
    pkt_t                       w_pkt;

    assign w_idle   = (r_state == e_idle) || (r_state == e_done);
    assign w_start  = w_idle && start_i;
    assign w_ovr_we = w_idle && ovr_v_i && (ovr_addr_i < field_id_width_p'(num_fields_p));
    assign w_hs     = cfg_v_o && cfg_ready_i;
    assign w_last   = r_field == last_field;
    assign w_adv    = w_hs && ((r_state == e_unfreeze) || (w_last && (freeze_release_p == 0)));

    assign w_mask = w_idle ? core_mask_i : r_mask;
    assign w_cur  = w_idle ? {(core_id_width_p + 1){1'b1}} : {1'b0, r_core};

    bp_cfg_next_core #(
        .num_core_p      (num_core_p),
        .core_id_width_p (core_id_width_p)
    ) next_core (
        .i_mask  (w_mask),
        .i_cur   (w_cur),
        .o_core  (w_next),
        .o_found (w_found)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_mask  <= '0;
            r_core  <= '0;
            r_field <= '0;
            for (int i = 0; i < num_fields_p; i++)
                r_table[i] <= default_fields_p[i*field_width_p +: field_width_p];
        end else begin
            if (w_ovr_we)
                r_table[ovr_addr_i[fiw-1:0]] <= ovr_data_i;
            if (w_start || w_adv) begin
                r_core  <= w_next;
                r_field <= '0;
                r_state <= w_found ? e_send : e_done;
            end else if (w_hs && w_last) begin
                r_state <= e_unfreeze;
            end else if (w_hs) begin
                r_field <= r_field + field_id_width_p'(1);
            end
            if (w_start)
                r_mask <= core_mask_i;
        end
    end

    always_comb begin
        w_pkt.core  = r_core;
        w_pkt.field = (r_state == e_unfreeze) ? freeze_idx : r_field;
        w_pkt.data  = (r_state == e_unfreeze) ? '0 : r_table[r_field[fiw-1:0]];
    end

    assign cfg_v_o     = (r_state == e_send) || (r_state == e_unfreeze);
    assign busy_o      = cfg_v_o;
    assign done_o      = r_state == e_done;
    assign ovr_ready_o = w_idle;
    assign cfg_core_o  = w_pkt.core;
    assign cfg_field_o = w_pkt.field;
    assign cfg_data_o  = w_pkt.data;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb_bp_cfg_loader: directed broadcasts with a packet scoreboard and a negedge monitor
module tb_bp_cfg_loader;

    localparam logic [511:0] DEF = {
        64'hC0DE_0007_0000_0707, 64'hC0DE_0006_0000_0606,
        64'hC0DE_0005_0000_0505, 64'hC0DE_0004_0000_0404,
        64'hC0DE_0003_0000_0303, 64'hC0DE_0002_0000_0202,
        64'hC0DE_0001_0000_0101, 64'hC0DE_0000_0000_0000
    };

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [3:0]  core_mask_i;
    logic        ovr_v_i;
    logic        ovr_ready_o;
    logic [3:0]  ovr_addr_i;
    logic [63:0] ovr_data_i;
    logic        cfg_v_o;
    logic        cfg_ready_i;
    logic [1:0]  cfg_core_o;
    logic [3:0]  cfg_field_o;
    logic [63:0] cfg_data_o;
    logic        busy_o;
    logic        done_o;

    logic [69:0] sb [$];
    logic [63:0] tb_tab [8];
    int nchk = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    bp_cfg_loader #(
        .num_core_p       (4),
        .num_fields_p     (8),
        .field_width_p    (64),
        .default_fields_p (DEF),
        .freeze_release_p (1)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .core_mask_i (core_mask_i),
        .ovr_v_i     (ovr_v_i),
        .ovr_ready_o (ovr_ready_o),
        .ovr_addr_i  (ovr_addr_i),
        .ovr_data_i  (ovr_data_i),
        .cfg_v_o     (cfg_v_o),
        .cfg_ready_i (cfg_ready_i),
        .cfg_core_o  (cfg_core_o),
        .cfg_field_o (cfg_field_o),
        .cfg_data_o  (cfg_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_defaults();
        for (int i = 0; i < 8; i++) tb_tab[i] = DEF[i*64 +: 64];
    endtask

    task automatic push_exp(input logic [3:0] m);
        for (int c = 0; c < 4; c++)
            if (m[c]) begin
                for (int f = 0; f < 8; f++) sb.push_back({2'(c), 4'(f), tb_tab[f]});
                sb.push_back({2'(c), 4'hF, 64'h0});
            end
    endtask

    // probe: 0 none, 1 override attempt while busy, 2 start pulse while busy
    task automatic bcast(input logic [3:0] m, input bit tog, input bit ovr, input logic [3:0] oa,
                         input logic [63:0] od, input int probe, input int exp_n);
        int n;
        if (ovr && oa < 4'd8) tb_tab[oa[2:0]] = od;
        push_exp(m);
        @(posedge clk_i); #1;
        start_i = 1'b1; core_mask_i = m;
        ovr_v_i = ovr; ovr_addr_i = oa; ovr_data_i = od;
        chk("ovr_ready_idle", 72'(ovr_ready_o), 72'd1);
        @(posedge clk_i); #1;
        start_i = 1'b0; ovr_v_i = 1'b0;
        cfg_ready_i = !tog;
        chk("cfg_v_after_start", 72'(cfg_v_o), 72'(m != 4'd0));
        chk("done_after_start", 72'(done_o), 72'(m == 4'd0));
        n = 0;
        while (!done_o && n < 400) begin
            @(posedge clk_i); #1;
            n++;
            if (tog) cfg_ready_i = !cfg_ready_i;
            if (probe == 1 && n == 4) begin
                ovr_v_i = 1'b1; ovr_addr_i = 4'd5; ovr_data_i = 64'h1234_5678;
                chk("ovr_ready_busy", 72'(ovr_ready_o), 72'd0);
            end
            if (probe == 2 && n == 3) begin
                start_i = 1'b1; core_mask_i = 4'b1111;
                chk("busy_during_send", 72'(busy_o), 72'd1);
            end
            if (n == 5) begin
                ovr_v_i = 1'b0; start_i = 1'b0;
            end
        end
        cfg_ready_i = 1'b1;
        chk("bcast_cycles", 72'(n), 72'(exp_n));
        chk("done_level", 72'(done_o), 72'd1);
        chk("busy_at_done", 72'(busy_o), 72'd0);
        chk("sb_drained", 72'(sb.size()), 72'd0);
        sb.delete();
    endtask

    initial begin : monitor
        logic        pv;
        logic [69:0] pp, cur, e;
        pv = 1'b0;
        pp = '0;
        forever begin
            @(negedge clk_i);
            cur = {cfg_core_o, cfg_field_o, cfg_data_o};
            if (reset_i) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    chk("stall_valid", 72'(cfg_v_o), 72'd1);
                    chk("stall_payload", 72'(cur), 72'(pp));
                end
                if (cfg_v_o && cfg_ready_i) begin
                    if (sb.size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL unexpected_pkt: got %h expected none", cur);
                    end else begin
                        e = sb.pop_front();
                        chk("pkt", 72'(cur), 72'(e));
                    end
                end
                pv = cfg_v_o && !cfg_ready_i;
                pp = cur;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        reset_i = 1'b1; start_i = 1'b0; core_mask_i = '0;
        ovr_v_i = 1'b0; ovr_addr_i = '0; ovr_data_i = '0; cfg_ready_i = 1'b1;
        load_defaults();
        #1;
        chk("rst_cfg_v", 72'(cfg_v_o), 72'd0);
        chk("rst_busy", 72'(busy_o), 72'd0);
        chk("rst_done", 72'(done_o), 72'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b0;
        chk("idle_ovr_ready", 72'(ovr_ready_o), 72'd1);

        bcast(4'b1111, 0, 0, 4'd0, 64'd0, 0, 36);
        bcast(4'b1111, 1, 0, 4'd0, 64'd0, 0, 72);
        bcast(4'b1111, 0, 1, 4'd3, 64'h0000_0000_DEAD_BEEF, 1, 36);
        bcast(4'b1010, 0, 0, 4'd0, 64'd0, 0, 18);
        bcast(4'b0000, 0, 1, 4'd9, 64'hBAD0_0000_0000_0009, 0, 0);
        bcast(4'b0100, 0, 1, 4'd8, 64'hBAD0_0000_0000_0008, 0, 9);

        push_exp(4'b1111);
        @(posedge clk_i); #1;
        start_i = 1'b1; core_mask_i = 4'b1111;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        k = 0;
        while (!(cfg_v_o && cfg_core_o == 2'd1 && cfg_field_o == 4'd2) && k < 100) begin
            @(posedge clk_i); #1;
            k++;
        end
        chk("reach_core1_field2", 72'(k < 100), 72'd1);
        cfg_ready_i = 1'b0;
        @(posedge clk_i); #1;
        chk("held_before_reset", 72'(cfg_v_o), 72'd1);
        #1 reset_i = 1'b1;
        #1;
        chk("async_rst_cfg_v", 72'(cfg_v_o), 72'd0);
        chk("async_rst_busy", 72'(busy_o), 72'd0);
        chk("async_rst_done", 72'(done_o), 72'd0);
        sb.delete();
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b0; cfg_ready_i = 1'b1;
        chk("post_rst_ovr_ready", 72'(ovr_ready_o), 72'd1);
        chk("post_rst_done", 72'(done_o), 72'd0);
        chk("post_rst_cfg_v", 72'(cfg_v_o), 72'd0);
        load_defaults();
        bcast(4'b0001, 0, 0, 4'd0, 64'd0, 0, 9);
        bcast(4'b0001, 0, 0, 4'd0, 64'd0, 2, 9);

        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
Runtime successor to the static processor-config table. Holds a parametrised table of config fields, initialised from defaults and overridable by a host. On command, it broadcasts every field to every enabled core over a valid/ready config-write channel, then sends each core a freeze-release write. Sits between the host/boot interface and the per-tile config buses; core count, field count and field width are parameters.

Parameters:
num_core_p, 4, number of cores addressed.
num_fields_p, 8, config fields per core.
field_width_p, 64, data width of each field.
default_fields_p, '0, packed num_fields_p*field_width_p reset value of the table; field i at bits [i*field_width_p +: field_width_p].
freeze_release_p, 1, 1 = append a freeze-release write per core.
core_id_width_p, `BSG_SAFE_CLOG2(num_core_p), derived.
field_id_width_p, `BSG_SAFE_CLOG2(num_fields_p+1), derived; the all-ones value is the freeze-release index.

Ports:
clk_i  in  1  clock.
reset_i  in  1  asynchronous, active-high reset.
start_i  in  1  begin broadcast; honoured in IDLE/DONE only.
core_mask_i  in  num_core_p  enabled cores; sampled at start.
ovr_v_i  in  1  host override-write valid.
ovr_ready_o  out  1  override accepted; high only in IDLE/DONE.
ovr_addr_i  in  field_id_width_p  field index to override.
ovr_data_i  in  field_width_p  override value.
cfg_v_o  out  1  config write valid.
cfg_ready_i  in  1  config write ready.
cfg_core_o  out  core_id_width_p  destination core.
cfg_field_o  out  field_id_width_p  field index, or all-ones for freeze-release.
cfg_data_o  out  field_width_p  field data; 0 for freeze-release.
busy_o  out  1  in SEND/UNFREEZE.
done_o  out  1  in DONE.

Behaviour:
- Reset, asynchronous: state=IDLE, table=default_fields_p, mask register=0, counters=0. cfg_v_o, busy_o and done_o all 0. cfg_v_o drops in the same cycle reset asserts.
- States: IDLE, SEND, UNFREEZE, DONE.
- Override: a write happens on ovr_v_i & ovr_ready_o. An ovr_addr_i >= num_fields_p is accepted and discarded.
- Override and start in the same cycle: the override commits first. The broadcast uses the new value.
- IDLE/DONE with start_i: latch core_mask_i and select the lowest set bit as the current core.
  - Mask = 0: go to DONE the next cycle. No cfg_v_o is issued.
  - Otherwise: go to SEND with field=0.
  - cfg_v_o rises the cycle after start_i.
- SEND: cfg_v_o=1, payload = {current core, field, table[field]}.
  - A handshake on cfg_v_o & cfg_ready_i advances the field.
  - After field num_fields_p-1: go to UNFREEZE if freeze_release_p=1, else advance the core.
- UNFREEZE: one write with cfg_field_o = all-ones and data 0. On handshake, advance the core.
- Core advance: jump to the next set mask bit above the current core, with field=0, and stay in SEND. Masked cores cost zero cycles. If no set bit remains, go to DONE.
- Payload stability: once cfg_v_o is high, cfg_v_o and the payload stay stable until handshake. No retraction.
- Throughput: one packet per cycle while cfg_ready_i is held high.
- Illegal inputs while busy: start_i is ignored. ovr_v_i is not accepted (ovr_ready_o=0).
- DONE: done_o=1 until the next start_i (re-broadcast) or reset.
- Packet count per broadcast = popcount(mask) * (num_fields_p + freeze_release_p).

Decomposition:
- Shared package holds:
  - state enum bp_cfg_loader_state_e;
  - packed struct bp_cfg_pkt_s {core, field, data} as a parametrised-width macro;
  - freeze-release index constant.
- Sub-module bp_cfg_next_core (combinational): given mask and current core, returns the next set bit strictly above it plus a found flag. It is reused for the initial pick via current = -1.

Test Plan:
1. Defaults (num_core_p=4, num_fields_p=8), mask 4'b1111, cfg_ready_i=1, start at cycle t -> 36 packets on cycles t+1..t+36, first = {0,0,default[0]}, 9th = {0,4'hF,0}; done_o=1 at t+37.
2. Same config with cfg_ready_i toggling 1/0 each cycle -> payload and cfg_v_o held stable across stall cycles; packet sequence identical to scenario 1; 72 cycles.
3. Override addr 3 = 64'hDEAD_BEEF asserted in the same cycle as start_i -> every core receives field 3 = DEAD_BEEF; ovr_ready_o=0 during SEND, and a second override issued then is not applied.
4. Mask 4'b1010 -> 18 packets, cores 1 then 3 only, no idle cycles between them. Mask 4'b0000 -> done_o the cycle after start, cfg_v_o never asserted.
5. Async reset mid-SEND (core 1, field 2, cfg_ready_i=0) -> cfg_v_o, busy_o and done_o drop in the same cycle; after release the table holds defaults and the state is IDLE.
6. start_i in DONE with mask 4'b0001 -> full re-broadcast to core 0 only (9 packets); start_i pulsed during SEND is ignored.
